pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Frame-synchronous controller that selects which test pattern the pixel datapath renders.
- Watches the timing counters to detect frame boundaries. Holds each pattern for a programmable number of frames, or advances on a manual step request.
- Changes the selection only at a frame start, so no frame ever mixes two patterns.
- Sits between the timing generator / user buttons and the pattern mux in front of the RGB output registers.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns (2..8); pattern_sel wraps from NUM_PATTERNS-1 to 0
HOLD_FRAMES, 60, frames each pattern is shown in auto mode (1..255)

Ports:
clk  input  1  pixel clock; hpos/vpos advance once per clk
reset  input  1  synchronous, active-low reset
hpos  input  12  current horizontal position from the timing generator
vpos  input  12  current vertical position from the timing generator
auto_en  input  1  1 = advance automatically every HOLD_FRAMES frames; 0 = manual only
pause  input  1  1 = freeze the auto hold counter (manual step still honoured)
step  input  1  manual advance request, level or pulse; rising edge counts
pattern_sel  output  3  active pattern index for the pattern mux
frame_tick  output  1  one-clk pulse at each detected frame start
pattern_changed  output  1  one-clk pulse coincident with a pattern_sel update
hold_count  output  8  frames elapsed on the current pattern (saturates at 255)

Behaviour:
- Reset (reset==0 sampled at posedge clk): pattern_sel=0, frame_tick=0, pattern_changed=0, hold_count=0, step pending cleared, state=WAIT_SYNC. Edge-detect history registers for step and frame start cleared to 0.
- Frame start detection:
  - fs_cond = (hpos==0 && vpos==0).
  - frame_tick pulses one clk after the rising edge of fs_cond, i.e. registered at the clk following the first cycle fs_cond is seen high.
  - fs_cond held high for several clks produces exactly one frame_tick.
- Step detection: registered rising edge of step sets step_pending. Multiple edges before the next frame_tick coalesce into a single advance.
- States:
  - WAIT_SYNC: ignore the hold counter until the first frame_tick, then go to SHOW. That frame_tick does not advance the pattern. A step edge in WAIT_SYNC is latched and applied at the second frame_tick.
  - SHOW: on each frame_tick, advance if step_pending, or if (auto_en && !pause && hold_count+1 >= HOLD_FRAMES); otherwise hold_count increments (saturating at 255; it does not advance while pause=1 and auto_en=1).
- Advance, done on the frame_tick clk edge:
  - pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1.
  - hold_count <= 0, step_pending cleared, pattern_changed=1 for that single clk.
  - Auto expiry and step_pending on the same tick advance exactly one position.
- A step edge arriving on the same clk as frame_tick is latched for the next frame; it is not applied immediately.
- Latency: pattern_sel changes 2 clks after the first clk fs_cond is high (edge register + update register).
- auto_en=0: hold_count still counts frames (saturating); only step advances.
- Reset mid-frame: everything returns to reset values on the next clk; sequencing restarts in WAIT_SYNC.

Optional Feature:
- Macro PATTERN_SEQ_BLANK_EN.
- Defined:
  - Adds output port blank_frame (1 bit, reset 0) and state BLANK.
  - Every advance first enters BLANK for one full frame with blank_frame=1; pattern_sel already shows the new index.
  - The next frame_tick returns to SHOW with blank_frame=0 and hold_count=0.
  - Blank frames do not count toward HOLD_FRAMES.
  - Step edges during BLANK stay pending and are applied at the first SHOW frame_tick.
- Undefined: no blank_frame port, no BLANK state; advance goes directly SHOW->SHOW.

Test Plan:
- Reset low 4 clks, release, drive 3 frames (frame = 800x525 counts) with auto_en=1, HOLD_FRAMES=2 -> pattern_sel 0 through first two frame_ticks (WAIT_SYNC + 1), becomes 1 at third tick; pattern_changed pulses once.
- NUM_PATTERNS=4, auto_en=1, HOLD_FRAMES=1, run 6 frames -> pattern_sel sequence 0,1,2,3,0,1; wrap 3->0 verified.
- auto_en=0, three step pulses within one frame -> exactly one advance at next frame_tick (0->1); no change without further steps.
- auto_en=1, HOLD_FRAMES=3, pause=1 for 5 frames -> pattern_sel constant, hold_count frozen; pause=0 -> advance after remaining frames.
- Step edge on same clk as frame_tick at hold expiry -> advance by 1 at that tick, second advance at following tick.
- PATTERN_SEQ_BLANK_EN defined, HOLD_FRAMES=1 -> blank_frame=1 for exactly one frame after each change; assert reset mid-blank -> blank_frame=0, pattern_sel=0 next clk.

Source files
------------

// File: rtl/pattern_sequencer_if.sv
// Bundle between the timing generator / button logic and the pattern sequencer.
// blank_frame only exists when PATTERN_SEQ_BLANK_EN is defined.
interface pattern_sequencer_if;
    logic [11:0] hpos;
    logic [11:0] vpos;
    logic        auto_en;
    logic        pause;
    logic        step;
    logic [2:0]  pattern_sel;
    logic        frame_tick;
    logic        pattern_changed;
    logic [7:0]  hold_count;
`ifdef PATTERN_SEQ_BLANK_EN
    logic        blank_frame;
`endif

    modport master (
        output hpos, vpos, auto_en, pause, step,
        input  pattern_sel, frame_tick, pattern_changed, hold_count
`ifdef PATTERN_SEQ_BLANK_EN
        , input blank_frame
`endif
    );

    modport slave (
        input  hpos, vpos, auto_en, pause, step,
        output pattern_sel, frame_tick, pattern_changed, hold_count
`ifdef PATTERN_SEQ_BLANK_EN
        , output blank_frame
`endif
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test pattern selector; changes pattern only at frame start.
// Define PATTERN_SEQ_BLANK_EN to insert one blank frame after every pattern change.
module pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned HOLD_FRAMES  = 60
) (
    input logic                clk,
    input logic                reset,
    pattern_sequencer_if.slave bus
);
    localparam logic [1:0] StWaitSync = 2'd0;
    localparam logic [1:0] StShow     = 2'd1;
`ifdef PATTERN_SEQ_BLANK_EN
    localparam logic [1:0] StBlank    = 2'd2;
`endif
    localparam logic [2:0] LastPattern = 3'(NUM_PATTERNS - 1);
    localparam logic [8:0] HoldLimit   = 9'(HOLD_FRAMES);

    logic [1:0] state_q, state_d;
    logic       fs_q;
    logic       frame_tick_q, frame_tick_d;
    logic       step_q;
    logic       step_pending_q, step_pending_d;
    logic [2:0] pattern_sel_q, pattern_sel_d;
    logic       pattern_changed_q, pattern_changed_d;
    logic [7:0] hold_count_q, hold_count_d;
`ifdef PATTERN_SEQ_BLANK_EN
    logic       blank_q, blank_d;
`endif

    logic fs_cond, step_rise, auto_expire, advance;

    assign fs_cond     = (bus.hpos == '0) && (bus.vpos == '0);
    assign step_rise   = bus.step & ~step_q;
    assign auto_expire = bus.auto_en && !bus.pause && (({1'b0, hold_count_q} + 9'd1) >= HoldLimit);
    assign advance     = frame_tick_q && (state_q == StShow) && (step_pending_q || auto_expire);

    always_comb begin
        frame_tick_d      = fs_cond & ~fs_q;
        state_d           = state_q;
        pattern_sel_d     = pattern_sel_q;
        hold_count_d      = hold_count_q;
        pattern_changed_d = 1'b0;
        // A step edge on the consuming tick survives into the next frame.
        step_pending_d    = (advance ? 1'b0 : step_pending_q) | step_rise;
`ifdef PATTERN_SEQ_BLANK_EN
        blank_d           = blank_q;
`endif
        if (frame_tick_q) begin
            case (state_q)
                StWaitSync: state_d = StShow;
                StShow: begin
                    if (advance) begin
                        pattern_sel_d     = (pattern_sel_q == LastPattern) ? 3'd0
                                                                           : pattern_sel_q + 3'd1;
                        hold_count_d      = '0;
                        pattern_changed_d = 1'b1;
`ifdef PATTERN_SEQ_BLANK_EN
                        state_d           = StBlank;
                        blank_d           = 1'b1;
`endif
                    end else if (!(bus.auto_en && bus.pause) && hold_count_q != 8'hFF) begin
                        hold_count_d = hold_count_q + 8'd1;
                    end
                end
`ifdef PATTERN_SEQ_BLANK_EN
                StBlank: begin
                    state_d      = StShow;
                    blank_d      = 1'b0;
                    hold_count_d = '0;
                end
`endif
                default: state_d = StWaitSync;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= StWaitSync;
            fs_q              <= 1'b0;
            frame_tick_q      <= 1'b0;
            step_q            <= 1'b0;
            step_pending_q    <= 1'b0;
            pattern_sel_q     <= '0;
            pattern_changed_q <= 1'b0;
            hold_count_q      <= '0;
`ifdef PATTERN_SEQ_BLANK_EN
            blank_q           <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            fs_q              <= fs_cond;
            frame_tick_q      <= frame_tick_d;
            step_q            <= bus.step;
            step_pending_q    <= step_pending_d;
            pattern_sel_q     <= pattern_sel_d;
            pattern_changed_q <= pattern_changed_d;
            hold_count_q      <= hold_count_d;
`ifdef PATTERN_SEQ_BLANK_EN
            blank_q           <= blank_d;
`endif
        end
    end

    assign bus.pattern_sel     = pattern_sel_q;
    assign bus.frame_tick      = frame_tick_q;
    assign bus.pattern_changed = pattern_changed_q;
    assign bus.hold_count      = hold_count_q;
`ifdef PATTERN_SEQ_BLANK_EN
    assign bus.blank_frame     = blank_q;
`endif
endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer using short 10x3 frames.
// Expected pattern indices are queued by stimulus and popped on pattern_changed.
module tb_pattern_sequencer;
    localparam int HTot = 10;
    localparam int VTot = 3;

    logic clk = 1'b0;
    logic reset;
    pattern_sequencer_if bus ();

    pattern_sequencer #(
        .NUM_PATTERNS(4),
        .HOLD_FRAMES (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cur_idx = -1;
    int ticks = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: frame phase of pulses and scoreboard pop on each pattern change.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.frame_tick) begin
                ticks++;
                check("frame_tick_phase", cur_idx, 1);
            end
            if (bus.pattern_changed) begin
                check("changed_phase", cur_idx, 2);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change: pattern_sel=%0d, no advance expected",
                             bus.pattern_sel);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check("pattern_sel", int'(bus.pattern_sel), int'(e));
                    check("hold_on_change", int'(bus.hold_count), 0);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset    = 1'b0;
        bus.hpos = 12'd5;
        bus.vpos = 12'd1;
        bus.step = 1'b0;
        cur_idx  = -1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        ticks = 0;
    endtask

    task automatic run_frame(input logic [31:0] step_mask);
        for (int idx = 0; idx < HTot * VTot; idx++) begin
            bus.hpos = 12'(idx % HTot);
            bus.vpos = 12'(idx / HTot);
            bus.step = step_mask[idx];
            cur_idx  = idx;
            @(posedge clk);
            #1;
        end
        cur_idx  = -1;
        bus.hpos = 12'd5;
        bus.vpos = 12'd1;
        bus.step = 1'b0;
    endtask

    initial begin
        bus.auto_en = 1'b1;
        bus.pause   = 1'b0;
        do_reset(4);
        check("rst_sel", int'(bus.pattern_sel), 0);
        check("rst_tick", int'(bus.frame_tick), 0);
        check("rst_changed", int'(bus.pattern_changed), 0);
        check("rst_hold", int'(bus.hold_count), 0);
`ifdef PATTERN_SEQ_BLANK_EN
        check("rst_blank", int'(bus.blank_frame), 0);
        run_frame(0);
        run_frame(0);
        exp_q.push_back(3'd1);
        run_frame(0);
        check("blank_on_sel", int'(bus.pattern_sel), 1);
        check("blank_on", int'(bus.blank_frame), 1);
        run_frame(0);
        check("blank_off", int'(bus.blank_frame), 0);
        check("blank_off_hold", int'(bus.hold_count), 0);
        run_frame(0);
        check("post_blank_hold", int'(bus.hold_count), 1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        run_frame(32'h0000_0400);
        check("blank2", int'(bus.blank_frame), 1);
        run_frame(0);
        check("blank_step_held", int'(bus.pattern_sel), 2);
        check("blank_step_off", int'(bus.blank_frame), 0);
        run_frame(0);
        check("blank_step_sel", int'(bus.pattern_sel), 3);
        check("blank3", int'(bus.blank_frame), 1);
        check("blank_queue", exp_q.size(), 0);
        do_reset(1);
        check("midblank_rst_blank", int'(bus.blank_frame), 0);
        check("midblank_rst_sel", int'(bus.pattern_sel), 0);
`else
        // First advance: WAIT_SYNC tick, one counted frame, then expiry.
        run_frame(0);
        check("t1_f1_sel", int'(bus.pattern_sel), 0);
        check("t1_f1_hold", int'(bus.hold_count), 0);
        run_frame(0);
        check("t1_f2_sel", int'(bus.pattern_sel), 0);
        check("t1_f2_hold", int'(bus.hold_count), 1);
        exp_q.push_back(3'd1);
        run_frame(0);
        check("t1_f3_sel", int'(bus.pattern_sel), 1);
        check("t1_ticks", ticks, 3);

        // Wrap 3 -> 0 under auto advance.
        for (int f = 4; f <= 11; f++) begin
            if (f % 2 == 1) exp_q.push_back(3'(((f - 3) / 2 + 1) % 4));
            run_frame(0);
        end
        check("wrap_sel", int'(bus.pattern_sel), 1);
        check("wrap_queue", exp_q.size(), 0);

        // Step latched in WAIT_SYNC is applied at the second tick.
        do_reset(2);
        bus.auto_en = 1'b0;
        exp_q.push_back(3'd1);
        run_frame(32'h0000_0001);
        check("ws_step_held", int'(bus.pattern_sel), 0);
        run_frame(0);
        check("ws_step_sel", int'(bus.pattern_sel), 1);

        // Three step pulses in one frame coalesce into one advance.
        run_frame(32'h0000_02A0);
        check("coal_pre", int'(bus.pattern_sel), 1);
        exp_q.push_back(3'd2);
        run_frame(0);
        run_frame(0);
        run_frame(0);
        check("coal_sel", int'(bus.pattern_sel), 2);
        check("coal_hold", int'(bus.hold_count), 2);
        check("coal_queue", exp_q.size(), 0);

        // Pause freezes hold counter; release resumes the countdown.
        do_reset(2);
        bus.auto_en = 1'b1;
        run_frame(0);
        run_frame(0);
        bus.pause = 1'b1;
        repeat (5) run_frame(0);
        check("pause_sel", int'(bus.pattern_sel), 0);
        check("pause_hold", int'(bus.hold_count), 1);
        bus.pause = 1'b0;
        exp_q.push_back(3'd1);
        run_frame(0);
        check("unpause_sel", int'(bus.pattern_sel), 1);
        check("pause_queue", exp_q.size(), 0);

        // Step on the frame_tick clk at expiry: auto now, step next frame.
        do_reset(2);
        run_frame(0);
        run_frame(0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        run_frame(32'h0000_0002);
        check("coinc_sel1", int'(bus.pattern_sel), 1);
        run_frame(0);
        check("coinc_sel2", int'(bus.pattern_sel), 2);
        check("coinc_queue", exp_q.size(), 0);

        // Manual mode still counts frames and saturates at 255.
        do_reset(2);
        bus.auto_en = 1'b0;
        repeat (260) run_frame(0);
        check("sat_hold", int'(bus.hold_count), 255);
        check("sat_sel", int'(bus.pattern_sel), 0);
        check("sat_ticks", ticks, 260);
        do_reset(1);
        check("rst2_hold", int'(bus.hold_count), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
